// File: rtl/an_scan_hm_pkg.sv
// Shared types and constants for the health-monitor anode scanner.
//   MODE_RT / MODE_PM : encodings of the mode input
//   bcd_t             : one BCD digit
//   ANODES_OFF        : active-low "all anodes dark" pattern (slice to NUM_DIGITS)
package an_scan_hm_pkg;

  localparam logic MODE_RT = 1'b0;
  localparam logic MODE_PM = 1'b1;

  typedef logic [3:0] bcd_t;

  localparam int MAX_DIGITS = 8;
  localparam logic [MAX_DIGITS-1:0] ANODES_OFF = '1;

endpackage

// File: rtl/tick_gen_hm.sv
// Refresh prescaler: counts 0..TICK_DIV-1 and pulses tick for one cycle on
// the last count. clr restarts the period from 0 and suppresses the tick.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : synchronous restart (mode change)
//   tick       : one-cycle pulse every TICK_DIV cycles
module tick_gen_hm #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST) && !clr;

  always_ff @(posedge clk) begin
    if (!rst_n)               cnt <= '0;
    else if (clr || cnt == LAST) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/an_scan_hm.sv
// Time-multiplexed anode scanner for the health-monitor seven-segment display.
// Steps a digit index through the digits active in the current mode, one slot
// per TICK_DIV clocks, and registers the active-low anode pattern together
// with the BCD nibble of the selected digit.
//   clk, rst_n : clock, synchronous active-low reset
//   mode       : 0 reaction timer (RT_DIGITS), 1 pulse monitor (PM_DIGITS)
//   rs_en      : display enable in reaction-timer mode
//   blank_lz   : blank leading zero digits (digit 0 always shown)
//   digit_val  : packed BCD digits, digit 0 in the low nibble
//   an_l       : registered active-low anodes
//   digit_out  : registered BCD nibble aligned with an_l
//   sel        : registered current digit index
module an_scan_hm
  import an_scan_hm_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int RT_DIGITS  = 4,
  parameter int PM_DIGITS  = 3,
  parameter int TICK_DIV   = 100000,
  localparam int SEL_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic                    rs_en,
  input  logic                    blank_lz,
  input  logic [4*NUM_DIGITS-1:0] digit_val,
  output logic [NUM_DIGITS-1:0]   an_l,
  output logic [3:0]              digit_out,
  output logic [SEL_W-1:0]        sel
);

  // One bit wider than sel so a count equal to NUM_DIGITS is representable.
  localparam int CNT_W = SEL_W + 1;
  localparam logic [NUM_DIGITS-1:0] OFF = ANODES_OFF[NUM_DIGITS-1:0];

  logic                  mode_q;
  logic                  mode_chg;
  logic                  tick;
  logic                  disp_en;
  logic                  in_range;
  logic                  nz_tail;
  logic                  lz;
  logic [CNT_W-1:0]      n_act;
  logic [CNT_W-1:0]      sel_w;
  logic [SEL_W-1:0]      sel_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;
  bcd_t                  dig_nxt;

  assign mode_chg = (mode != mode_q);
  assign n_act    = (mode == MODE_PM) ? CNT_W'(PM_DIGITS) : CNT_W'(RT_DIGITS);
  assign sel_w    = {1'b0, sel};
  assign in_range = (sel_w < n_act);
  assign disp_en  = rs_en | mode;

  tick_gen_hm #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mode_chg),
    .tick  (tick)
  );

  // Digit index next state. Mode change wins over tick; an index stranded
  // beyond the active count (left over from a mode change) is pulled back.
  always_comb begin
    sel_nxt = sel;
    if (mode_chg || !in_range)
      sel_nxt = '0;
    else if (tick)
      sel_nxt = (sel_w == n_act - 1'b1) ? '0 : sel + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel    <= '0;
      mode_q <= MODE_RT;
    end else begin
      sel    <= sel_nxt;
      mode_q <= mode;
    end
  end

  // A digit is a leading zero when it and every more significant active digit
  // are zero.
  always_comb begin
    nz_tail = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (CNT_W'(i) >= sel_w && CNT_W'(i) < n_act && digit_val[4*i +: 4] != 4'd0)
        nz_tail = 1'b1;
    end
  end

  assign lz = blank_lz && (sel != '0) && !nz_tail;

  // in_range keeps the stale index dark during the cycle a mode change lands.
  always_comb begin
    an_nxt  = OFF;
    dig_nxt = bcd_t'(digit_val[4*sel +: 4]);
    if (disp_en && !lz && in_range)
      an_nxt = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << sel);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_l      <= OFF;
      digit_out <= '0;
    end else begin
      an_l      <= an_nxt;
      digit_out <= dig_nxt;
    end
  end

endmodule

// File: tb/tb_an_scan_hm.sv
// Directed bench for an_scan_hm with TICK_DIV=4, 8 digits, RT=4, PM=3.
// Inputs change just after a falling edge; outputs are checked on falling edges.
module tb_an_scan_hm;

  localparam int ND = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mode;
  logic          rs_en;
  logic          blank_lz;
  logic [4*ND-1:0] digit_val;
  logic [ND-1:0] an_l;
  logic [3:0]    digit_out;
  logic [SW-1:0] sel;

  int n_chk  = 0;
  int n_fail = 0;

  an_scan_hm #(
    .NUM_DIGITS (ND),
    .RT_DIGITS  (4),
    .PM_DIGITS  (3),
    .TICK_DIV   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .rs_en     (rs_en),
    .blank_lz  (blank_lz),
    .digit_val (digit_val),
    .an_l      (an_l),
    .digit_out (digit_out),
    .sel       (sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Two reset edges, released on a falling edge: the next step() lands after
  // the first active edge.
  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  logic [7:0] rt_pat [4] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
  logic [7:0] pm_pat [3] = '{8'hFE, 8'hFD, 8'hFB};
  logic [3:0] pm_dig [3] = '{4'h2, 4'h7, 4'h0};

  initial begin
    mode = 1'b0; rs_en = 1'b1; blank_lz = 1'b0; digit_val = 32'h8765_4321;

    // ---- reset state and RT scan ----
    rst_n = 1'b0;
    step(2);
    chk("rst_an", an_l, 8'hFF);
    chk("rst_sel", sel, 0);
    chk("rst_dig", digit_out, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("rt_an", an_l, rt_pat[((k-1)/4) % 4]);
      chk("rt_dig", digit_out, 4'(((k-1)/4) % 4 + 1));
      chk("rt_hi_off", an_l[7:4], 4'hF);
    end

    // ---- PM scan, rs_en ignored; mode change seen on first edge ----
    mode = 1'b1; rs_en = 1'b0; digit_val = 32'h0000_0072;
    do_reset();
    step();
    chk("pm_first", an_l, 8'hFE);
    for (int k = 2; k <= 13; k++) begin
      step();
      chk("pm_an", an_l, pm_pat[((k-2)/4) % 3]);
      chk("pm_dig", digit_out, pm_dig[((k-2)/4) % 3]);
    end

    // ---- mode switch while sel=3 ----
    mode = 1'b0; rs_en = 1'b1; digit_val = 32'h8765_4321;
    do_reset();
    step(13);
    chk("sw_pre_sel", sel, 3);
    chk("sw_pre_an", an_l, 8'hF7);
    mode = 1'b1;
    step();                                   // switch edge
    chk("sw_sel0", sel, 0);
    chk("sw_an_dark", an_l, 8'hFF);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("sw_hi_off", an_l[7:3], 5'h1F);
      if (k <= 4) chk("sw_an", an_l, 8'hFE);
      if (k == 3) chk("sw_hold_sel", sel, 0);
      if (k == 4) chk("sw_adv_sel", sel, 1);
      if (k == 5) chk("sw_an_next", an_l, 8'hFD);
    end

    // ---- enable gating ----
    mode = 1'b0; rs_en = 1'b1;
    do_reset();
    step(5);
    chk("en_pre_an", an_l, 8'hFD);
    rs_en = 1'b0;
    step();
    chk("en_off_an", an_l, 8'hFF);
    chk("en_off_sel", sel, 1);
    rs_en = 1'b1;
    step();
    chk("en_back_an", an_l, 8'hFD);
    chk("en_back_sel", sel, 1);
    step(2);
    chk("en_next_an", an_l, 8'hFB);

    // ---- leading-zero blanking ----
    blank_lz = 1'b1; digit_val = 32'h0000_0005;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("lz5_an", an_l, (((k-1)/4) % 4 == 0) ? 8'hFE : 8'hFF);
    end
    digit_val = 32'h0000_0105;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("lz105_an", an_l, (((k-1)/4) % 4 == 3) ? 8'hFF : rt_pat[((k-1)/4) % 4]);
    end

    // ---- reset mid-scan ----
    blank_lz = 1'b0; digit_val = 32'h8765_4321;
    do_reset();
    step(9);
    chk("mr_pre_sel", sel, 2);
    chk("mr_pre_an", an_l, 8'hFB);
    rst_n = 1'b0;
    step();
    chk("mr_an", an_l, 8'hFF);
    chk("mr_sel", sel, 0);
    rst_n = 1'b1;
    step();
    chk("mr_first", an_l, 8'hFE);
    step(2);
    chk("mr_hold_sel", sel, 0);
    step();
    chk("mr_adv_sel", sel, 1);
    step();
    chk("mr_next_an", an_l, 8'hFD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
